// File: rtl/musb_gpr_wr_arbiter.sv
// Write-port arbiter for the 32x32 GPR file: pipeline writeback vs. multi-cycle unit.
// Define MUSB_GPR_INIT_EN to include the post-reset clear of r1..r31.
module musb_gpr_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        wb_we,
    output logic        wb_hold,
    input  logic [4:0]  mc_wa,
    input  logic [31:0] mc_wd,
    input  logic        mc_req,
    output logic        mc_gnt,
    output logic        init_busy,
    output logic [4:0]  gpr_wa,
    output logic [31:0] gpr_wd,
    output logic        gpr_we
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;
    logic       wb_active;
    logic       preempt;
    logic       run_gnt;

    // A writeback to r0 is architecturally a no-op, so it never blocks the mc unit.
    assign wb_active = wb_we && (wb_wa != 5'd0);
    assign preempt   = (wait_cnt == LIMIT);
    assign run_gnt   = mc_req && (!wb_active || preempt);

`ifdef MUSB_GPR_INIT_EN
    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t     state;
    logic [4:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            clr_cnt  <= 5'd1;
            wait_cnt <= 4'd0;
        end else if (state == INIT) begin
            clr_cnt  <= clr_cnt + 5'd1;
            wait_cnt <= 4'd0;
            if (clr_cnt == 5'd31) begin
                state <= RUN;
            end
        end else begin
            if (run_gnt || !mc_req) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // During the clear sequence the write port is owned by clr_cnt and requests are ignored.
    always_comb begin
        if (state == INIT) begin
            gpr_wa    = clr_cnt;
            gpr_wd    = 32'd0;
            gpr_we    = 1'b1;
            init_busy = 1'b1;
            wb_hold   = wb_we;
            mc_gnt    = 1'b0;
        end else begin
            gpr_wa    = run_gnt ? mc_wa : wb_wa;
            gpr_wd    = run_gnt ? mc_wd : wb_wd;
            gpr_we    = run_gnt | wb_we;
            init_busy = 1'b0;
            wb_hold   = wb_active && run_gnt;
            mc_gnt    = run_gnt;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (run_gnt || !mc_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        gpr_wa    = run_gnt ? mc_wa : wb_wa;
        gpr_wd    = run_gnt ? mc_wd : wb_wd;
        gpr_we    = run_gnt | wb_we;
        init_busy = 1'b0;
        wb_hold   = wb_active && run_gnt;
        mc_gnt    = run_gnt;
    end
`endif

endmodule

// File: tb/tb_musb_gpr_wr_arbiter.sv
// Scoreboard bench for musb_gpr_wr_arbiter; follows MUSB_GPR_INIT_EN to pick the expected reset behaviour.
module tb_musb_gpr_wr_arbiter;
    localparam int STARVE_LIMIT = 4;
`ifdef MUSB_GPR_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        wb_we;
    logic        wb_hold;
    logic [4:0]  mc_wa;
    logic [31:0] mc_wd;
    logic        mc_req;
    logic        mc_gnt;
    logic        init_busy;
    logic [4:0]  gpr_wa;
    logic [31:0] gpr_wd;
    logic        gpr_we;

    musb_gpr_wr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_we(wb_we), .wb_hold(wb_hold),
        .mc_wa(mc_wa), .mc_wd(mc_wd), .mc_req(mc_req), .mc_gnt(mc_gnt),
        .init_busy(init_busy),
        .gpr_wa(gpr_wa), .gpr_wd(gpr_wd), .gpr_we(gpr_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gnt;
        logic        hold;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_init   = 1'b0;
    int          m_clr    = 1;
    int          m_wait   = 0;
    bit          model_valid = 1'b0;
    logic        last_gnt  = 1'b0;
    logic        last_hold = 1'b0;
    logic        obs_gnt, obs_hold, obs_busy;
    logic [31:0] ref_rf[32];
    logic [31:0] dut_rf[32];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference behaviour for the current state and the inputs just driven.
    function automatic exp_t modelOutputs();
        exp_t e;
        logic real_wb;
        if (m_init) begin
            e.we = 1'b1; e.wa = 5'(m_clr); e.wd = 32'd0;
            e.gnt = 1'b0; e.hold = wb_we; e.busy = 1'b1;
        end else begin
            real_wb = wb_we && (wb_wa != 5'd0);
            e.gnt   = mc_req && (!real_wb || (m_wait == STARVE_LIMIT));
            e.hold  = real_wb && e.gnt;
            e.busy  = 1'b0;
            e.we    = e.gnt ? 1'b1 : wb_we;
            e.wa    = e.gnt ? mc_wa : wb_wa;
            e.wd    = e.gnt ? mc_wd : wb_wd;
        end
        return e;
    endfunction

    task automatic updateModel(input logic r, input logic req, input logic gnt);
        if (r) begin
            m_init = INIT_EN; m_clr = 1; m_wait = 0;
        end else if (m_init) begin
            if (m_clr == 31) m_init = 1'b0;
            m_clr++;
            m_wait = 0;
        end else if (gnt || !req) begin
            m_wait = 0;
        end else if (m_wait < STARVE_LIMIT) begin
            m_wait++;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic req,
                                 input logic [4:0] mwa, input logic [31:0] mwd);
        exp_t e, got;
        @(posedge clk);
        #1;
        rst = r; wb_we = we; wb_wa = wa; wb_wd = wd;
        mc_req = req; mc_wa = mwa; mc_wd = mwd;
        e = modelOutputs();
        if (model_valid) sb.push_back(e);
        @(negedge clk);
        obs_gnt = mc_gnt; obs_hold = wb_hold; obs_busy = init_busy;
        if (gpr_we === 1'b1 && gpr_wa != 5'd0) dut_rf[gpr_wa] = gpr_wd;
        if (model_valid) begin
            got = sb.pop_front();
            checkOutput("gpr_we", 32'(gpr_we), 32'(got.we));
            checkOutput("gpr_wa", 32'(gpr_wa), 32'(got.wa));
            checkOutput("gpr_wd", gpr_wd, got.wd);
            checkOutput("mc_gnt", 32'(mc_gnt), 32'(got.gnt));
            checkOutput("wb_hold", 32'(wb_hold), 32'(got.hold));
            checkOutput("init_busy", 32'(init_busy), 32'(got.busy));
            if (got.we && got.wa != 5'd0) ref_rf[got.wa] = got.wd;
        end
        last_gnt  = e.gnt;
        last_hold = e.hold;
        updateModel(r, req, e.gnt);
        model_valid = 1'b1;
    endtask

    initial begin
        logic [4:0]  wa_cur, mwa_cur;
        logic [31:0] wd_cur, mwd_cur;
        logic        we_cur, req, mc_pend, hold_at_gnt;
        int          busy_cnt, gnt_at;

        rst = 1'b1; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        mc_req = 1'b0; mc_wa = '0; mc_wd = '0;
        for (int i = 0; i < 32; i++) begin
            ref_rf[i] = 'x;
            dut_rf[i] = 'x;
        end

        // Reset then idle: the clear sequence (if built in) runs r1..r31.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            if (obs_busy === 1'b1) busy_cnt++;
        end
        checkOutput("init_busy_cycles", 32'(busy_cnt), INIT_EN ? 32'd31 : 32'd0);
        if (INIT_EN) checkOutput("r31_cleared", dut_rf[31], 32'd0);

        applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("r5", dut_rf[5], 32'hDEADBEEF);

        applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        checkOutput("mc_gnt_idle", 32'(obs_gnt), 32'd1);
        checkOutput("r7", dut_rf[7], 32'h12345678);

        // Back-to-back writebacks starve the mc request until preemption.
        wa_cur = 5'd10; wd_cur = 32'h10000000; req = 1'b1; gnt_at = 0; hold_at_gnt = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, 1, wa_cur, wd_cur, req, 5'd9, 32'hA5A5A5A5);
            if (obs_gnt === 1'b1 && gnt_at == 0) begin
                gnt_at = i;
                hold_at_gnt = obs_hold;
            end
            if (last_gnt) req = 1'b0;
            if (!last_hold) begin
                wa_cur++;
                wd_cur++;
            end
        end
        checkOutput("starve_gnt_cycle", 32'(gnt_at), 32'(STARVE_LIMIT + 1));
        checkOutput("starve_hold", 32'(hold_at_gnt), 32'd1);
        checkOutput("r9", dut_rf[9], 32'hA5A5A5A5);
        checkOutput("r14_held_wb", dut_rf[14], 32'h10000004);

        applyStimulus(0, 1, 5'd0, 32'hFFFF0000, 1, 5'd20, 32'h0BADF00D);
        checkOutput("r0_wb_gnt", 32'(obs_gnt), 32'd1);
        checkOutput("r0_wb_hold", 32'(obs_hold), 32'd0);
        checkOutput("r20", dut_rf[20], 32'h0BADF00D);

        // Reset while an mc request is pending behind writeback.
        applyStimulus(0, 1, 5'd3, 32'h33333333, 1, 5'd21, 32'hCAFE0001);
        applyStimulus(1, 1, 5'd4, 32'h44444444, 1, 5'd21, 32'hCAFE0001);
        gnt_at = 0;
        for (int i = 1; i <= 40 && gnt_at == 0; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 5'd21, 32'hCAFE0001);
            if (obs_gnt === 1'b1) gnt_at = i;
        end
        checkOutput("rst_regnt_cycle", 32'(gnt_at), INIT_EN ? 32'd32 : 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Random traffic obeying the hold/request protocol.
        mc_pend = 1'b0; mwa_cur = '0; mwd_cur = '0;
        we_cur = 1'b0; wa_cur = '0; wd_cur = '0; last_hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!last_hold) begin
                we_cur = ($urandom_range(0, 9) < 7);
                wa_cur = 5'($urandom_range(0, 31));
                wd_cur = $urandom;
            end
            if (!mc_pend && $urandom_range(0, 3) == 0) begin
                mc_pend = 1'b1;
                mwa_cur = 5'($urandom_range(0, 31));
                mwd_cur = $urandom;
            end
            applyStimulus(0, we_cur, wa_cur, wd_cur, mc_pend, mwa_cur, mwd_cur);
            if (last_gnt) mc_pend = 1'b0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        for (int r = 1; r < 32; r++) begin
            checkOutput($sformatf("rf_r%0d", r), dut_rf[r], ref_rf[r]);
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/musb_gpr_wr_arbiter.md
# musb_gpr_wr_arbiter

Write-port controller for the 32x32 general-purpose register file, placed between the pipeline writeback stage, the multi-cycle arithmetic unit (mul/div) and the register file's single write port. After reset it clears r1..r31, because the register file has no reset. During normal operation it grants the write port each cycle, either to pipeline writeback (default priority) or to the multi-cycle unit. A starvation counter stops the multi-cycle unit from waiting indefinitely behind back-to-back writebacks.

## Interface
- STARVE_LIMIT, default 4: consecutive ungranted cycles of a pending multi-cycle request before it preempts writeback. Legal range 1..15.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- wb_wa  in  5  pipeline writeback register address
- wb_wd  in  32  pipeline writeback data
- wb_we  in  1  pipeline writeback enable
- wb_hold  out  1  writeback not performed this cycle; pipeline holds wb_* stable and re-presents them
- mc_wa  in  5  multi-cycle unit register address
- mc_wd  in  32  multi-cycle unit data
- mc_req  in  1  multi-cycle unit write request; held with mc_wa/mc_wd until granted
- mc_gnt  out  1  multi-cycle write performed this cycle
- init_busy  out  1  clear sequence in progress; pipeline must stall
- gpr_wa  out  5  register file write address
- gpr_wd  out  32  register file write data
- gpr_we  out  1  register file write enable

## Operation
- State machine with two states: INIT and RUN. Registers: state, 5-bit clear counter clr_cnt, 4-bit wait counter wait_cnt.
- Reset: state=INIT, clr_cnt=1, wait_cnt=0.
- INIT outputs: gpr_wa=clr_cnt, gpr_wd=0, gpr_we=1, init_busy=1, wb_hold=wb_we, mc_gnt=0.
  - clr_cnt increments every cycle.
  - In the cycle where clr_cnt=31, the next state is RUN.
- RUN:
  - wb_active = wb_we && (wb_wa != 0).
  - preempt = (wait_cnt == STARVE_LIMIT).
  - mc_gnt = mc_req && (!wb_active || preempt).
  - wb_hold = wb_active && mc_gnt.
  - If mc_gnt: gpr_wa/gpr_wd = mc_wa/mc_wd and gpr_we=1.
  - Otherwise: gpr_wa/gpr_wd = wb_wa/wb_wd and gpr_we = wb_we.
  - init_busy=0.
- wait_cnt rules:
  - Cleared when mc_gnt=1 or mc_req=0.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Address 0:
  - A writeback to r0 counts as idle, so a pending mc_req is granted in that cycle.
  - An mc write to r0 is granted normally and has no architectural effect.
- Same address in the same cycle with no preemption: writeback writes, mc waits. The later mc write wins. Ordering hazards belong to the pipeline's hazard unit, not this block.
- After a grant, the multi-cycle unit may present a new request in the next cycle.
- Reset during RUN:
  - Any pending mc request is dropped (mc_gnt=0 while in INIT).
  - The full clear sequence reruns.
  - The requester re-issues after init_busy falls.

## Timing
- Arbitration and output muxing are combinational with zero latency. The register file captures gpr_* at the same rising edge on which the grant is given.
- The clear sequence takes exactly 31 cycles after the reset cycle. init_busy falls in cycle 32, counting the first cycle with rst=0 as cycle 1.
- Worst-case mc wait under continuous writeback is STARVE_LIMIT cycles; the grant comes in the cycle after wait_cnt reaches STARVE_LIMIT.
- Writeback delay is at most 1 cycle per preemption. Preemption cannot repeat back to back, because wait_cnt clears on grant.

## Configuration
- MUSB_GPR_INIT_EN defined: INIT state and clear sequence present as described above.
- Not defined:
  - Reset goes straight to RUN.
  - init_busy is tied to 0 and clr_cnt is not implemented.
  - Register contents are undefined until software writes them.

## Test plan
- Reset, then 40 idle cycles → r1..r31 written with 0 in address order 1..31, init_busy=1 for exactly 31 cycles, reads of all registers return 0x00000000.
- RUN, wb_we=1 wb_wa=5 wb_wd=0xDEADBEEF while mc_req=0 → gpr_we=1, gpr_wa=5, wb_hold=0, r5=0xDEADBEEF.
- RUN, mc_req=1 mc_wa=7 mc_wd=0x12345678, no writeback → mc_gnt=1 in the same cycle, r7=0x12345678, wait_cnt stays 0.
- STARVE_LIMIT=4, wb_we=1 with nonzero addresses every cycle, and mc_req=1 → mc_gnt=0 for 4 cycles, grant in the 5th with wb_hold=1 in that cycle. The held writeback completes in the 6th cycle with the same address and data.
- mc_req=1 pending with wb_we=1 and wb_wa=0 → mc_gnt=1 immediately, wb_hold=0.
- rst pulsed while mc_req=1 is pending in RUN → mc_gnt=0 throughout a fresh 31-cycle clear. The re-issued request is granted in the first RUN cycle.
